// File: rtl/port_arbiter_pkg.sv
// Shared types and constants for the router output-side merge stage.
package port_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ARB_DEPTH = 4;

  typedef logic [1:0] port_id_t;

  typedef struct packed {
    port_id_t    dest;
    logic [15:0] payload;
  } pkt_t;

endpackage

// File: rtl/port_arbiter_if.sv
// Lane-side and link-side handshake bundle of the output merge stage.
import port_arbiter_pkg::*;

interface port_arbiter_if;
  pkt_t                 in_pkt [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  pkt_t                 out_pkt;
  logic                 out_valid;
  logic                 out_ready;
  port_id_t             grant_id;

  modport master (
    output in_pkt, in_valid, out_ready,
    input  in_ready, out_pkt, out_valid, grant_id
  );

  modport slave (
    input  in_pkt, in_valid, out_ready,
    output in_ready, out_pkt, out_valid, grant_id
  );
endinterface

// File: rtl/port_arbiter_fifo.sv
// Per-lane packet FIFO; DEPTH must be a power of two so the pointers wrap naturally.
import port_arbiter_pkg::*;

module pkt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  pkt_t                       din,
  output pkt_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  pkt_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Packet storage; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/port_arbiter.sv
// Four-lane merge stage: lane FIFOs, arbiter and registered output link.
// Define ROUTER_ARB_FIXED_PRIO_EN for fixed priority (lane 0 highest) instead of round-robin.
import port_arbiter_pkg::*;

module port_arbiter #(
  parameter int DEPTH = ARB_DEPTH
) (
  input logic           clock,
  input logic           reset,
  port_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);

  pkt_t                 fifo_dout_s  [NUM_PORTS];
  logic [CW-1:0]        fifo_count_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full_s;
  logic [NUM_PORTS-1:0] fifo_empty_s;
  logic [NUM_PORTS-1:0] push_s;
  logic [NUM_PORTS-1:0] pop_s;
  logic [NUM_PORTS-1:0] in_ready_s;
  logic                 free_s;
  logic                 grant_s;
  port_id_t             winner_s;
  port_id_t             idx_s;
  pkt_t                 out_pkt_r;
  logic                 out_valid_r;
  port_id_t             grant_id_r;
`ifndef ROUTER_ARB_FIXED_PRIO_EN
  port_id_t             last_grant_r;
`endif

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    // Readiness is derived from occupancy only: a full lane never pushes through a same-cycle pop.
    assign in_ready_s[i] = (fifo_count_s[i] < CW'(DEPTH));
    assign push_s[i]     = bus.in_valid[i] && !fifo_full_s[i];
    assign pop_s[i]      = grant_s && (winner_s == port_id_t'(i));

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .din   (bus.in_pkt[i]),
      .dout  (fifo_dout_s[i]),
      .full  (fifo_full_s[i]),
      .empty (fifo_empty_s[i]),
      .count (fifo_count_s[i])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_pkt   = out_pkt_r;
  assign bus.out_valid = out_valid_r;
  assign bus.grant_id  = grant_id_r;

  // Winner search: scan lowest priority first so the highest-priority non-empty lane is written last.
  always_comb begin
    free_s   = !out_valid_r || bus.out_ready;
    grant_s  = free_s && !(&fifo_empty_s);
    winner_s = 2'd0;
    idx_s    = 2'd0;
`ifdef ROUTER_ARB_FIXED_PRIO_EN
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx_s = port_id_t'(k);
      if (!fifo_empty_s[idx_s]) begin
        winner_s = idx_s;
      end else begin
        winner_s = winner_s;
      end
    end
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx_s = last_grant_r + port_id_t'(k);
      if (!fifo_empty_s[idx_s]) begin
        winner_s = idx_s;
      end else begin
        winner_s = winner_s;
      end
    end
`endif
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_pkt_r    <= '0;
      out_valid_r  <= 1'b0;
      grant_id_r   <= 2'd0;
`ifndef ROUTER_ARB_FIXED_PRIO_EN
      last_grant_r <= 2'd3;
`endif
    end else if (grant_s) begin
      out_pkt_r    <= fifo_dout_s[winner_s];
      out_valid_r  <= 1'b1;
      grant_id_r   <= winner_s;
`ifndef ROUTER_ARB_FIXED_PRIO_EN
      last_grant_r <= winner_s;
`endif
    end else if (free_s) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_port_arbiter.sv
// Directed self-checking bench for port_arbiter (default round-robin build, DEPTH=4).
import port_arbiter_pkg::*;

module tb_port_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  port_arbiter_if bus();

  port_arbiter #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic pkt_t mk(input logic [1:0] dest, input logic [15:0] payload);
    pkt_t p;
    p.dest    = dest;
    p.payload = payload;
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.in_pkt[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_pkt !== 18'h0) begin errors++; $display("FAIL reset_pkt: got %h expected 0", bus.out_pkt); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
    checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b expected 1111", bus.in_ready); end
  endtask

  task automatic test_single();
    pkt_t exp_p;
    do_reset();
    exp_p = mk(2'd2, 16'hA5C3);
    bus.in_pkt[1]   = exp_p;
    bus.in_valid[1] = 1'b1;
    step();                       // edge 0: push
    bus.in_valid[1] = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b expected 0", bus.out_valid); end
    step();                       // edge 1: granted
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_pkt !== exp_p) begin errors++; $display("FAIL single_pkt: got %h expected %h", bus.out_pkt, exp_p); end
    checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d expected 1", bus.grant_id); end
    step();                       // edge 2: drained
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_all_lanes();
    do_reset();
    for (int i = 0; i < 4; i++) bus.in_pkt[i] = mk(2'(i), 16'h0100 + 16'(i));
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b expected 1", k, bus.out_valid); end
      checks++; if (bus.grant_id !== 2'(k)) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, bus.grant_id, k); end
      checks++; if (bus.out_pkt !== mk(2'(k), 16'h0100 + 16'(k))) begin errors++; $display("FAIL rr_pkt[%0d]: got %h expected %h", k, bus.out_pkt, mk(2'(k), 16'h0100 + 16'(k))); end
    end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    pkt_t exp_q [$];
    pkt_t got_q [$];
    logic rdy;
    do_reset();
    bus.out_ready   = 1'b0;
    bus.in_pkt[0]   = mk(2'd0, 16'h00F0);
    bus.in_valid[0] = 1'b1;
    exp_q.push_back(mk(2'd0, 16'h00F0));
    step();                       // lane 0 packet queued
    bus.in_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_pkt[2]   = mk(2'd1, 16'h2000 + 16'(k));
      bus.in_valid[2] = 1'b1;
      exp_q.push_back(mk(2'd1, 16'h2000 + 16'(k)));
      step();
      checks++; if (bus.in_ready[2] !== (k < 3)) begin errors++; $display("FAIL bp_ready[%0d]: got %0b expected %0b", k, bus.in_ready[2], (k < 3)); end
    end
    bus.in_pkt[2] = mk(2'd1, 16'h2004);
    exp_q.push_back(mk(2'd1, 16'h2004));
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (bus.in_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_full_hold[%0d]: got %0b expected 0", k, bus.in_ready[2]); end
      checks++; if (bus.out_pkt !== mk(2'd0, 16'h00F0) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_stable[%0d]: got %h/%0b expected %h/1", k, bus.out_pkt, bus.out_valid, mk(2'd0, 16'h00F0)); end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (bus.out_valid) got_q.push_back(bus.out_pkt);
      rdy = bus.in_ready[2];
      step();
      if (bus.in_valid[2] && rdy) bus.in_valid[2] = 1'b0;
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_toggle();
    port_id_t exp_g [4];
    pkt_t     exp_p [4];
    do_reset();
    exp_g = '{2'd0, 2'd3, 2'd0, 2'd3};
    exp_p = '{mk(2'd3, 16'h0A00), mk(2'd0, 16'h0D00), mk(2'd3, 16'h0A01), mk(2'd0, 16'h0D01)};
    bus.in_pkt[0] = exp_p[0];
    bus.in_pkt[3] = exp_p[1];
    bus.in_valid  = 4'b1001;
    step();
    bus.in_pkt[0] = exp_p[2];
    bus.in_pkt[3] = exp_p[3];
    step();
    bus.in_valid = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      checks++; if (bus.grant_id !== exp_g[j] || bus.out_pkt !== exp_p[j] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL tog_grant[%0d]: got %0d/%h expected %0d/%h", j, bus.grant_id, bus.out_pkt, exp_g[j], exp_p[j]); end
      bus.out_ready = 1'b0;
      step();
      checks++; if (bus.grant_id !== exp_g[j] || bus.out_pkt !== exp_p[j] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL tog_stable[%0d]: got %0d/%h expected %0d/%h", j, bus.grant_id, bus.out_pkt, exp_g[j], exp_p[j]); end
      bus.out_ready = 1'b1;
      step();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL tog_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus.in_pkt[i] = mk(2'(i), 16'hBEE0 + 16'(i));
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = 4'b0000;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded: got %0b expected 1", bus.out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_pkt !== 18'h0) begin errors++; $display("FAIL mid_pkt: got %h expected 0", bus.out_pkt); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: got %0d expected 0", bus.grant_id); end
    checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL mid_ready: got %b expected 1111", bus.in_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %0b expected 0", k, bus.out_valid); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_lanes();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_all_lanes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
